// File: rtl/recovery_sequencer_pkg.sv
// Shared types for the recovery sequencer: pipeline phase encoding, latched
// request record and wait-counter sizing.
package recovery_sequencer_pkg;

  localparam int RS_ADDR_WIDTH     = 32;
  localparam int RS_AL_INDEX_WIDTH = 6;
  localparam int RS_GHIST_WIDTH    = 10;
  localparam int RS_CNT_WIDTH      = 8;

  localparam logic [RS_CNT_WIDTH-1:0] RS_CNT_MAX = {RS_CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    COMMIT        = 2'd0,
    RECOVER_START = 2'd1,
    RECOVER_WAIT  = 2'd2
  } RecoveryPhase;

  typedef struct packed {
    logic [RS_ADDR_WIDTH-1:0]     pc;
    logic [RS_GHIST_WIDTH-1:0]    ghist;
    logic [RS_AL_INDEX_WIDTH-1:0] headPtr;
    logic [RS_AL_INDEX_WIDTH-1:0] tailPtr;
    logic                         flushAll;
    logic                         fromRw;
  } RecoveryRequestInfo;

endpackage

// File: rtl/recovery_source_arbiter.sv
// Combinational select between commit-stage and RW-stage recovery requests;
// the commit request is older and always wins. Also derives the flush range.
module recovery_source_arbiter
  import recovery_sequencer_pkg::*;
(
  input  logic                         i_commit_req,
  input  logic [RS_ADDR_WIDTH-1:0]     i_commit_pc,
  input  logic [RS_GHIST_WIDTH-1:0]    i_commit_ghist,
  input  logic [RS_AL_INDEX_WIDTH-1:0] i_commit_al_ptr,
  input  logic                         i_rw_req,
  input  logic [RS_ADDR_WIDTH-1:0]     i_rw_pc,
  input  logic [RS_GHIST_WIDTH-1:0]    i_rw_ghist,
  input  logic [RS_AL_INDEX_WIDTH-1:0] i_rw_al_ptr,
  input  logic [RS_AL_INDEX_WIDTH-1:0] i_al_tail_ptr,
  output logic                         o_valid,
  output RecoveryRequestInfo           o_info
);

  logic [RS_AL_INDEX_WIDTH-1:0] w_rw_head;

  // The mispredicted op itself survives; flushing starts one past it, wrapping.
  assign w_rw_head = i_rw_al_ptr + RS_AL_INDEX_WIDTH'(1);
  assign o_valid   = i_commit_req | i_rw_req;

  always_comb begin
    o_info         = '0;
    o_info.tailPtr = i_al_tail_ptr;
    if (i_commit_req) begin
      o_info.pc       = i_commit_pc;
      o_info.ghist    = i_commit_ghist;
      o_info.headPtr  = i_commit_al_ptr;
      o_info.flushAll = 1'b1;
      o_info.fromRw   = 1'b0;
    end else begin
      o_info.pc       = i_rw_pc;
      o_info.ghist    = i_rw_ghist;
      o_info.headPtr  = w_rw_head;
      o_info.flushAll = 1'b0;
      o_info.fromRw   = 1'b1;
    end
  end

endmodule

// File: rtl/recovery_sequencer.sv
// Pipeline phase FSM: COMMIT -> RECOVER_START (one cycle) -> RECOVER_WAIT until
// all flushable structures are idle. Optional watchdog: RSD_RECOVERY_WATCHDOG_EN.
module recovery_sequencer
  import recovery_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH          = RS_ADDR_WIDTH,
  parameter int AL_INDEX_WIDTH      = RS_AL_INDEX_WIDTH,
  parameter int GHIST_WIDTH         = RS_GHIST_WIDTH,
  parameter int MIN_RECOVERY_CYCLES = 2,
  parameter int WDT_LIMIT           = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      commit_req,
  input  logic [ADDR_WIDTH-1:0]     commit_pc,
  input  logic [GHIST_WIDTH-1:0]    commit_ghist,
  input  logic [AL_INDEX_WIDTH-1:0] commit_al_ptr,
  input  logic                      rw_req,
  input  logic [ADDR_WIDTH-1:0]     rw_pc,
  input  logic [GHIST_WIDTH-1:0]    rw_ghist,
  input  logic [AL_INDEX_WIDTH-1:0] rw_al_ptr,
  input  logic [AL_INDEX_WIDTH-1:0] al_tail_ptr,
  input  logic                      rmt_busy,
  input  logic                      iq_busy,
  input  logic                      replay_busy,
  input  logic                      wakeup_busy,
  output logic [1:0]                phase,
  output logic                      to_recovery,
  output logic                      to_commit,
  output logic [ADDR_WIDTH-1:0]     recovered_pc,
  output logic [GHIST_WIDTH-1:0]    recovered_ghist,
  output logic [AL_INDEX_WIDTH-1:0] flush_head_ptr,
  output logic [AL_INDEX_WIDTH-1:0] flush_tail_ptr,
  output logic                      flush_all,
  output logic                      from_rw,
  output logic                      unable_to_start,
  output logic                      wdt_error
);

  localparam logic [RS_CNT_WIDTH-1:0] MIN_M1 = RS_CNT_WIDTH'(MIN_RECOVERY_CYCLES - 1);
  localparam logic [RS_CNT_WIDTH-1:0] WDT_M1 = RS_CNT_WIDTH'(WDT_LIMIT - 1);

  RecoveryPhase            r_phase, w_phase_next;
  RecoveryRequestInfo      r_info, w_info_next, w_req_info;
  logic [RS_CNT_WIDTH-1:0] r_wait_cnt, w_wait_cnt_next;
  logic r_to_recovery, w_to_recovery_next;
  logic r_to_commit, w_to_commit_next;
  logic r_unable, w_unable_next;
  logic r_wdt_error, w_wdt_error_next;
  logic w_req_valid, w_all_idle, w_normal_exit, w_wdt_reached, w_wdt_hit, w_exit;

  recovery_source_arbiter u_arbiter (
    .i_commit_req    (commit_req),
    .i_commit_pc     (commit_pc),
    .i_commit_ghist  (commit_ghist),
    .i_commit_al_ptr (commit_al_ptr),
    .i_rw_req        (rw_req),
    .i_rw_pc         (rw_pc),
    .i_rw_ghist      (rw_ghist),
    .i_rw_al_ptr     (rw_al_ptr),
    .i_al_tail_ptr   (al_tail_ptr),
    .o_valid         (w_req_valid),
    .o_info          (w_req_info)
  );

  assign w_all_idle    = ~(rmt_busy | iq_busy | replay_busy | wakeup_busy);
  assign w_normal_exit = w_all_idle && (r_wait_cnt >= MIN_M1);
  assign w_wdt_reached = (r_wait_cnt >= WDT_M1);

`ifdef RSD_RECOVERY_WATCHDOG_EN
  assign w_wdt_hit = w_wdt_reached;
`else
  logic w_unused_wdt;
  assign w_unused_wdt = w_wdt_reached;
  assign w_wdt_hit    = 1'b0;
`endif

  assign w_exit = (r_phase == RECOVER_WAIT) && (w_normal_exit || w_wdt_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase       <= COMMIT;
      r_info        <= '0;
      r_wait_cnt    <= '0;
      r_to_recovery <= 1'b0;
      r_to_commit   <= 1'b0;
      r_unable      <= 1'b0;
      r_wdt_error   <= 1'b0;
    end else begin
      r_phase       <= w_phase_next;
      r_info        <= w_info_next;
      r_wait_cnt    <= w_wait_cnt_next;
      r_to_recovery <= w_to_recovery_next;
      r_to_commit   <= w_to_commit_next;
      r_unable      <= w_unable_next;
      r_wdt_error   <= w_wdt_error_next;
    end
  end

  always_comb begin
    w_phase_next = r_phase;
    case (r_phase)
      COMMIT:        if (w_req_valid) w_phase_next = RECOVER_START;
      RECOVER_START: w_phase_next = RECOVER_WAIT;
      RECOVER_WAIT:  if (w_exit) w_phase_next = COMMIT;
      default:       w_phase_next = COMMIT;
    endcase
  end

  // Requests outside COMMIT are dropped, not queued.
  always_comb begin
    w_info_next        = r_info;
    w_wait_cnt_next    = r_wait_cnt;
    w_to_recovery_next = 1'b0;
    w_to_commit_next   = 1'b0;
    w_wdt_error_next   = r_wdt_error;
    case (r_phase)
      COMMIT: begin
        if (w_req_valid) begin
          w_info_next        = w_req_info;
          w_to_recovery_next = 1'b1;
        end
      end
      RECOVER_START: w_wait_cnt_next = '0;
      RECOVER_WAIT: begin
        if (r_wait_cnt != RS_CNT_MAX) w_wait_cnt_next = r_wait_cnt + RS_CNT_WIDTH'(1);
        if (w_exit) w_to_commit_next = 1'b1;
        if (w_wdt_hit && !w_normal_exit) w_wdt_error_next = 1'b1;
      end
      default: w_wait_cnt_next = '0;
    endcase
    w_unable_next = (w_phase_next != COMMIT);
  end

  assign phase           = r_phase;
  assign to_recovery     = r_to_recovery;
  assign to_commit       = r_to_commit;
  assign recovered_pc    = r_info.pc;
  assign recovered_ghist = r_info.ghist;
  assign flush_head_ptr  = r_info.headPtr;
  assign flush_tail_ptr  = r_info.tailPtr;
  assign flush_all       = r_info.flushAll;
  assign from_rw         = r_info.fromRw;
  assign unable_to_start = r_unable;
  assign wdt_error       = r_wdt_error;

endmodule

// File: tb/tb_recovery_sequencer.sv
// Self-checking bench for recovery_sequencer: directed cases plus random
// traffic, compared every cycle against a behavioural model.
module tb_recovery_sequencer;

  localparam int AW      = 32;
  localparam int IW      = 6;
  localparam int GW      = 10;
  localparam int MIN_CYC = 2;
`ifdef RSD_RECOVERY_WATCHDOG_EN
  localparam int WDT    = 16;
  localparam bit WDT_ON = 1'b1;
`else
  localparam int WDT    = 255;
  localparam bit WDT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          commit_req, rw_req;
  logic [AW-1:0] commit_pc, rw_pc;
  logic [GW-1:0] commit_ghist, rw_ghist;
  logic [IW-1:0] commit_al_ptr, rw_al_ptr, al_tail_ptr;
  logic          rmt_busy, iq_busy, replay_busy, wakeup_busy;
  logic [1:0]    phase;
  logic          to_recovery, to_commit, flush_all, from_rw, unable_to_start, wdt_error;
  logic [AW-1:0] recovered_pc;
  logic [GW-1:0] recovered_ghist;
  logic [IW-1:0] flush_head_ptr, flush_tail_ptr;

  int vectors = 0;
  int miscompares = 0;

  recovery_sequencer #(
    .ADDR_WIDTH(AW), .AL_INDEX_WIDTH(IW), .GHIST_WIDTH(GW),
    .MIN_RECOVERY_CYCLES(MIN_CYC), .WDT_LIMIT(WDT)
  ) dut (
    .clk(clk), .rst(rst),
    .commit_req(commit_req), .commit_pc(commit_pc), .commit_ghist(commit_ghist),
    .commit_al_ptr(commit_al_ptr),
    .rw_req(rw_req), .rw_pc(rw_pc), .rw_ghist(rw_ghist), .rw_al_ptr(rw_al_ptr),
    .al_tail_ptr(al_tail_ptr),
    .rmt_busy(rmt_busy), .iq_busy(iq_busy), .replay_busy(replay_busy),
    .wakeup_busy(wakeup_busy),
    .phase(phase), .to_recovery(to_recovery), .to_commit(to_commit),
    .recovered_pc(recovered_pc), .recovered_ghist(recovered_ghist),
    .flush_head_ptr(flush_head_ptr), .flush_tail_ptr(flush_tail_ptr),
    .flush_all(flush_all), .from_rw(from_rw),
    .unable_to_start(unable_to_start), .wdt_error(wdt_error)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int            m_phase;      // 0 commit, 1 start, 2 wait
  int            m_wait;       // wait cycles elapsed
  logic          m_to_rec, m_to_commit, m_fa, m_rw, m_wdt;
  logic [AW-1:0] m_pc;
  logic [GW-1:0] m_gh;
  logic [IW-1:0] m_head, m_tail;

  task automatic model_reset();
    m_phase = 0; m_wait = 0;
    m_to_rec = 0; m_to_commit = 0; m_fa = 0; m_rw = 0; m_wdt = 0;
    m_pc = '0; m_gh = '0; m_head = '0; m_tail = '0;
  endtask

  task automatic model_step();
    bit idle, normal, forced;
    if (rst) begin
      model_reset();
      return;
    end
    m_to_rec = 0;
    m_to_commit = 0;
    case (m_phase)
      0: begin
        if (commit_req) begin
          m_pc = commit_pc; m_gh = commit_ghist; m_head = commit_al_ptr;
          m_tail = al_tail_ptr; m_fa = 1; m_rw = 0;
          m_phase = 1; m_to_rec = 1;
        end else if (rw_req) begin
          m_pc = rw_pc; m_gh = rw_ghist;
          m_head = IW'((int'(rw_al_ptr) + 1) % (1 << IW));
          m_tail = al_tail_ptr; m_fa = 0; m_rw = 1;
          m_phase = 1; m_to_rec = 1;
        end
      end
      1: begin
        m_phase = 2;
        m_wait = 0;
      end
      default: begin
        idle   = !(rmt_busy || iq_busy || replay_busy || wakeup_busy);
        normal = idle && (m_wait >= MIN_CYC - 1);
        forced = WDT_ON && (m_wait >= WDT - 1);
        if (normal || forced) begin
          m_phase = 0;
          m_to_commit = 1;
          if (!normal) m_wdt = 1;
        end
        if (m_wait < 255) m_wait++;
      end
    endcase
  endtask

  // ---------------- scoreboard / compare process ----------------
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
      #1;
      vectors++;
      if (int'(phase) != m_phase || to_recovery !== m_to_rec || to_commit !== m_to_commit ||
          recovered_pc !== m_pc || recovered_ghist !== m_gh || flush_head_ptr !== m_head ||
          flush_tail_ptr !== m_tail || flush_all !== m_fa || from_rw !== m_rw ||
          unable_to_start !== (m_phase != 0) || wdt_error !== m_wdt) begin
        miscompares++;
        $display("FAIL cycle_model t=%0t got ph=%0d trec=%0b tcm=%0b pc=%h gh=%h hd=%0d tl=%0d fa=%0b rw=%0b un=%0b wdt=%0b exp ph=%0d trec=%0b tcm=%0b pc=%h gh=%h hd=%0d tl=%0d fa=%0b rw=%0b un=%0b wdt=%0b",
                 $time, phase, to_recovery, to_commit, recovered_pc, recovered_ghist,
                 flush_head_ptr, flush_tail_ptr, flush_all, from_rw, unable_to_start, wdt_error,
                 m_phase, m_to_rec, m_to_commit, m_pc, m_gh, m_head, m_tail, m_fa, m_rw,
                 m_phase != 0, m_wdt);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    commit_req = 0; rw_req = 0;
    commit_pc = '0; rw_pc = '0; commit_ghist = '0; rw_ghist = '0;
    commit_al_ptr = '0; rw_al_ptr = '0; al_tail_ptr = '0;
    rmt_busy = 0; iq_busy = 0; replay_busy = 0; wakeup_busy = 0;
  endtask

  // Returns at the negedge of the first COMMIT cycle, or flags a timeout.
  task automatic wait_commit();
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (phase == 2'd0) seen = 1;
    end
    check("wait_commit_timeout", 32'(seen), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n2, ntc;
    rst = 1;
    drive_idle();
    repeat (3) @(negedge clk);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_unable", 32'(unable_to_start), 32'd0);
    check("rst_pc", recovered_pc, 32'd0);
    check("rst_wdt", 32'(wdt_error), 32'd0);
    rst = 0;

    // commit-stage request
    @(negedge clk);
    commit_req = 1; commit_pc = 32'h1000; commit_al_ptr = 5; al_tail_ptr = 20;
    commit_ghist = 10'h155;
    @(negedge clk);
    commit_req = 0;
    check("c_phase", 32'(phase), 32'd1);
    check("c_to_recovery", 32'(to_recovery), 32'd1);
    check("c_pc", recovered_pc, 32'h1000);
    check("c_ghist", 32'(recovered_ghist), 32'h155);
    check("c_head", 32'(flush_head_ptr), 32'd5);
    check("c_tail", 32'(flush_tail_ptr), 32'd20);
    check("c_flush_all", 32'(flush_all), 32'd1);
    check("c_from_rw", 32'(from_rw), 32'd0);
    check("c_unable", 32'(unable_to_start), 32'd1);
    @(negedge clk);
    check("c_wait_phase", 32'(phase), 32'd2);
    check("c_trec_once", 32'(to_recovery), 32'd0);
    wait_commit();
    check("c_to_commit", 32'(to_commit), 32'd1);

    // RW request with head-pointer wrap
    rw_req = 1; rw_pc = 32'h4444; rw_al_ptr = 63; al_tail_ptr = 3;
    @(negedge clk);
    rw_req = 0;
    check("rw_head_wrap", 32'(flush_head_ptr), 32'd0);
    check("rw_tail", 32'(flush_tail_ptr), 32'd3);
    check("rw_flush_all", 32'(flush_all), 32'd0);
    check("rw_from_rw", 32'(from_rw), 32'd1);
    check("rw_pc", recovered_pc, 32'h4444);
    wait_commit();

    // simultaneous requests, then an RW request dropped during RECOVER_WAIT
    commit_req = 1; commit_pc = 32'h200; rw_req = 1; rw_pc = 32'h300;
    @(negedge clk);
    commit_req = 0; rw_req = 0; rmt_busy = 1;
    check("both_pc", recovered_pc, 32'h200);
    check("both_from_rw", 32'(from_rw), 32'd0);
    repeat (3) @(negedge clk);
    check("drop_in_wait", 32'(phase), 32'd2);
    rw_req = 1; rw_pc = 32'hBEEF;
    @(negedge clk);
    rw_req = 0; rmt_busy = 0;
    wait_commit();
    check("drop_pc_kept", recovered_pc, 32'h200);
    check("drop_to_commit", 32'(to_commit), 32'd1);

    // request accepted in the to_commit cycle
    commit_req = 1; commit_pc = 32'h777;
    @(negedge clk);
    commit_req = 0;
    check("tc_accept_phase", 32'(phase), 32'd1);
    check("tc_accept_pc", recovered_pc, 32'h777);
    wait_commit();

    // iq_busy held for six RECOVER_WAIT cycles
    @(negedge clk);
    commit_req = 1; commit_pc = 32'h880; iq_busy = 1;
    n2 = 0; ntc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      commit_req = 0;
      if (phase == 2'd2) n2++;
      if (to_commit) ntc++;
      iq_busy = (n2 < 7);
    end
    check("iq_wait_cycles", 32'(n2), 32'd7);
    check("iq_to_commit_once", 32'(ntc), 32'd1);

`ifdef RSD_RECOVERY_WATCHDOG_EN
    // watchdog: rmt_busy stuck high
    rmt_busy = 1; commit_req = 1; commit_pc = 32'h990;
    n2 = 0; ntc = 0;
    for (int i = 0; i < 40 && ntc == 0; i++) begin
      @(negedge clk);
      commit_req = 0;
      if (phase == 2'd2) n2++;
      if (to_commit) ntc++;
    end
    check("wdt_wait_cycles", 32'(n2), 32'd16);
    check("wdt_to_commit", 32'(ntc), 32'd1);
    check("wdt_set", 32'(wdt_error), 32'd1);
    repeat (3) @(negedge clk);
    check("wdt_sticky", 32'(wdt_error), 32'd1);
    rst = 1;
    @(negedge clk);
    check("wdt_rst_clear", 32'(wdt_error), 32'd0);
    check("wdt_rst_phase", 32'(phase), 32'd0);
    @(negedge clk);
    rst = 0; rmt_busy = 0;
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst           = ($urandom_range(0, 399) == 0);
      commit_req    = ($urandom_range(0, 9) == 0);
      rw_req        = ($urandom_range(0, 6) == 0);
      commit_pc     = $urandom;
      rw_pc         = $urandom;
      commit_ghist  = GW'($urandom);
      rw_ghist      = GW'($urandom);
      commit_al_ptr = IW'($urandom);
      rw_al_ptr     = ($urandom_range(0, 3) == 0) ? IW'(63) : IW'($urandom);
      al_tail_ptr   = IW'($urandom);
      rmt_busy      = ($urandom_range(0, 3) == 0);
      iq_busy       = ($urandom_range(0, 3) == 0);
      replay_busy   = ($urandom_range(0, 5) == 0);
      wakeup_busy   = ($urandom_range(0, 5) == 0) || ((i / 200) % 4 == 3);
    end
    @(negedge clk);
    rst = 0;
    drive_idle();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
